rate_divider: RTL and testbench

//  Parametrised square-wave/tick generator from the board clock with runtime-selectable

---
 rtl/rate_divider.sv | 130 +++++++++++++
 tb/tb_rate_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rate_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rate_divider                                                  |
// | Description : Square-wave / tick generator, f_out = BASE_HZ * 2^mode.       |
// |               Mode changes take effect only on half-period boundaries.      |
// |               Pause via en; one-cycle tick on every hz_out edge.            |
// |               Optional macro CLKDIV_MODE_SYNC_EN adds a 2-flop synchroniser |
// |               on mode_hz for asynchronous switch inputs.                    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module rate_divider #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int BASE_HZ   = 1,
   parameter int NUM_MODES = 5,
   parameter int MODE_W    = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [MODE_W-1:0] mode_hz,
   output logic              hz_out,
   output logic              tick,
   output logic [MODE_W-1:0] mode_active
);

   // Half-period length in clock cycles for mode m, never below one cycle.
   function automatic int half_of(input int m);
      int div;
      div = CLK_HZ / (2 * BASE_HZ * (1 << m));
      return (div < 1) ? 1 : div;
   endfunction

   localparam int                c_HALF0    = half_of(0);
   localparam int                c_CNT_W    = $clog2(c_HALF0 + 1);
   localparam logic [MODE_W-1:0] c_MODE_MAX = MODE_W'(NUM_MODES - 1);

   logic [c_CNT_W-1:0] cnt_q, cnt_d;
   logic               hz_q, hz_d;
   logic               tick_q, tick_d;
   logic [MODE_W-1:0]  mode_q, mode_d;

   logic [MODE_W-1:0]  w_mode_src;
   logic [MODE_W-1:0]  w_mode_req;
   logic [c_CNT_W-1:0] w_half_m1;
   logic               w_at_end;
   logic [c_CNT_W-1:0] w_half_m1_tbl [NUM_MODES];

   // Terminal count (HALF-1) for each mode, fixed at elaboration.
   generate
      for (genvar g = 0; g < NUM_MODES; g++) begin : g_half
         assign w_half_m1_tbl[g] = c_CNT_W'(half_of(g) - 1);
      end
   endgenerate

`ifdef CLKDIV_MODE_SYNC_EN
   logic [MODE_W-1:0] sync1_q, sync2_q;

   // Two-stage synchroniser for an asynchronous mode switch bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= mode_hz;
         sync2_q <= sync1_q;
      end
   end

   assign w_mode_src = sync2_q;
`else
   assign w_mode_src = mode_hz;
`endif

   // Out-of-range requests clamp to the fastest valid mode.
   assign w_mode_req = (w_mode_src > c_MODE_MAX) ? c_MODE_MAX : w_mode_src;

   // Select terminal count of the mode currently applied.
   always_comb begin
      w_half_m1 = '0;
      for (int i = 0; i < NUM_MODES; i++) begin
         if (mode_q == MODE_W'(i)) begin
            w_half_m1 = w_half_m1_tbl[i];
         end
      end
   end

   assign w_at_end = (cnt_q == w_half_m1);

   // Next state: count, toggle at half-period end, mode latched only at boundaries.
   always_comb begin
      cnt_d  = cnt_q;
      hz_d   = hz_q;
      tick_d = 1'b0;
      mode_d = mode_q;
      if (en) begin
         if (w_at_end) begin
            cnt_d  = '0;
            hz_d   = ~hz_q;
            tick_d = 1'b1;
            mode_d = w_mode_req;
         end else begin
            cnt_d  = cnt_q + c_CNT_W'(1);
         end
      end else if (cnt_q == '0) begin
         // Paused at a boundary: a new selection can be applied immediately.
         mode_d = w_mode_req;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         hz_q   <= 1'b0;
         tick_q <= 1'b0;
         mode_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         hz_q   <= hz_d;
         tick_q <= tick_d;
         mode_q <= mode_d;
      end
   end

   assign hz_out      = hz_q;
   assign tick        = tick_q;
   assign mode_active = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_rate_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rate_divider                                               |
// | Description : Scoreboard bench for rate_divider (CLK_HZ=32, NUM_MODES=4,    |
// |               half-periods 16/8/4/2) plus directed timing checks.           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rate_divider;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [2:0] mode_hz = 3'd0;
   logic       hz_out;
   logic       tick;
   logic [2:0] mode_active;

   rate_divider #(
      .CLK_HZ   (32),
      .BASE_HZ  (1),
      .NUM_MODES(4),
      .MODE_W   (3)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .mode_hz    (mode_hz),
      .hz_out     (hz_out),
      .tick       (tick),
      .mode_active(mode_active)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       hz;
      logic       tk;
      logic [2:0] mode;
   } exp_t;

   exp_t q_exp[$];

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int         c_HALF[4] = '{16, 8, 4, 2};
   int         m_done = 0;
   logic       m_hz = 1'b0;
   logic       m_tick = 1'b0;
   logic [2:0] m_mode = 3'd0;
   logic [2:0] m_s1 = 3'd0;
   logic [2:0] m_s2 = 3'd0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock edge with the given inputs.
   task automatic model_step(input logic r, input logic e, input logic [2:0] m);
      logic [2:0] src;
      logic [2:0] req;
`ifdef CLKDIV_MODE_SYNC_EN
      src = m_s2;
`else
      src = m;
`endif
      req = (src > 3'd3) ? 3'd3 : src;
      if (r) begin
         m_done = 0; m_hz = 1'b0; m_tick = 1'b0; m_mode = 3'd0;
         m_s1 = 3'd0; m_s2 = 3'd0;
      end else begin
         m_s2 = m_s1;
         m_s1 = m;
         if (e) begin
            if (m_done + 1 >= c_HALF[m_mode]) begin
               m_done = 0; m_hz = ~m_hz; m_tick = 1'b1; m_mode = req;
            end else begin
               m_done++; m_tick = 1'b0;
            end
         end else begin
            m_tick = 1'b0;
            if (m_done == 0) m_mode = req;
         end
      end
   endtask

   // Drive one cycle, push the expected result, then compare after the edge.
   task automatic drive_cycle(input logic r, input logic e, input logic [2:0] m);
      exp_t x;
      rst = r; en = e; mode_hz = m;
      model_step(r, e, m);
      q_exp.push_back('{hz: m_hz, tk: m_tick, mode: m_mode});
      @(posedge clk); #1;
      x = q_exp.pop_front();
      check("sb_hz_out", int'(hz_out), int'(x.hz));
      check("sb_tick", int'(tick), int'(x.tk));
      check("sb_mode_active", int'(mode_active), int'(x.mode));
   endtask

   // Run until tick is seen; n = cycles taken, -1 if the budget expires.
   task automatic run_to_tick(input logic e, input logic [2:0] m, input int budget,
                              output int n);
      n = -1;
      for (int i = 1; i <= budget; i++) begin
         drive_cycle(1'b0, e, m);
         if (tick === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      int n;
      int total;
      int lat;

      // 1: reset, mode 0 timing
      drive_cycle(1'b1, 1'b0, 3'd0);
      drive_cycle(1'b1, 1'b0, 3'd0);
      check("rst_hz_out", int'(hz_out), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_mode_active", int'(mode_active), 0);
      run_to_tick(1'b1, 3'd0, 40, n);
      check("t1_first_tick_cycles", n, 16);
      check("t1_hz_after_first", int'(hz_out), 1);
      run_to_tick(1'b1, 3'd0, 40, n);
      check("t1_second_half_cycles", n, 16);
      check("t1_hz_after_second", int'(hz_out), 0);

      // 2: change to mode 2 at count 5 of a mode-0 half
      for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 3'd0);
      run_to_tick(1'b1, 3'd2, 40, n);
      check("t2_rest_of_half", n, 11);
      check("t2_mode_at_toggle", int'(mode_active), 2);
      run_to_tick(1'b1, 3'd2, 40, n);
      check("t2_new_half", n, 4);

      // 3: saturated request
      run_to_tick(1'b1, 3'd7, 40, n);
      check("t3_old_half", n, 4);
      check("t3_mode_sat", int'(mode_active), 3);
      run_to_tick(1'b1, 3'd7, 40, n);
      check("t3_half_a", n, 2);
      run_to_tick(1'b1, 3'd7, 40, n);
      check("t3_half_b", n, 2);

      // 4: mode 1, pause 10 cycles at count 3
      run_to_tick(1'b1, 3'd1, 40, n);
      check("t4_switch_half", n, 2);
      check("t4_mode", int'(mode_active), 1);
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 3'd1);
      for (int i = 0; i < 10; i++) drive_cycle(1'b0, 1'b0, 3'd1);
      run_to_tick(1'b1, 3'd1, 40, n);
      check("t4_resume_cycles", n, 5);
      total = (n < 0) ? -1 : 3 + 10 + n;
      check("t4_total_half", total, 18);

      // 5: reset mid-period while hz_out=1
      drive_cycle(1'b1, 1'b0, 3'd0);
      run_to_tick(1'b1, 3'd0, 40, n);
      check("t5_pre_tick", n, 16);
      for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b1, 3'd0);
      check("t5_hz_before_rst", int'(hz_out), 1);
      drive_cycle(1'b1, 1'b1, 3'd2);
      check("t5_rst_hz", int'(hz_out), 0);
      check("t5_rst_tick", int'(tick), 0);
      check("t5_rst_mode", int'(mode_active), 0);
      run_to_tick(1'b1, 3'd0, 40, n);
      check("t5_restart_cycles", n, 16);

      // 6: idle reselect with en=0 at count 0
      lat = -1;
      for (int i = 1; i <= 10; i++) begin
         drive_cycle(1'b0, 1'b0, 3'd3);
         if (mode_active == 3'd3) begin
            lat = i;
            break;
         end
      end
`ifdef CLKDIV_MODE_SYNC_EN
      check("t6_idle_reselect_latency", lat, 3);
`else
      check("t6_idle_reselect_latency", lat, 1);
`endif
      check("t6_hz_held", int'(hz_out), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
